// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared CPU constants: bus width, opcode map and legal-opcode mask.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int BUS_W = 8;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Bit n set means opcode n is legal.
  localparam logic [15:0] LEGAL_MASK_DEFAULT = 16'h803F;

  function automatic logic op_is_legal(input logic [15:0] mask, input logic [OP_W-1:0] op);
    return mask[op];
  endfunction

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/instruction_register.sv
// ============================================================================
// Module  : instruction_register
// Brief   : Holds the fetched instruction word; exposes opcode/operand, drives
//           the operand onto the shared bus, and tracks validity, halt,
//           bus-conflict and retired-instruction count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_register
  import cpu_pkg::*;
#(
  parameter logic [3:0]  HLT_OPCODE = OP_HLT,
  parameter logic [15:0] LEGAL_MASK = LEGAL_MASK_DEFAULT,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] bus_in,
  input  logic             load,
  input  logic             out_en,
  input  logic             clr,
  output logic [3:0]       opcode,
  output logic [3:0]       operand,
  output logic [BUS_W-1:0] bus_out,
  output logic             bus_oe,
  output logic             valid,
  output logic             illegal,
  output logic             halted,
  output logic             conflict,
  output logic [CNT_W-1:0] retired
);

  logic [BUS_W-1:0] r_ir;
  logic             r_valid;
  logic             r_halted;
  logic             r_conflict;
  logic [CNT_W-1:0] r_retired;

  logic             w_accept_load;

  // A load only takes effect when neither halt nor clear outranks it.
  assign w_accept_load = load & ~clr & ~r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_conflict <= 1'b0;
      r_retired  <= '0;
    end else if (!r_halted) begin
      if (clr) begin
        r_ir    <= '0;
        r_valid <= 1'b0;
      end else if (load) begin
        r_ir      <= bus_in;
        r_valid   <= 1'b1;
        r_retired <= r_retired + CNT_W'(1);
        if (bus_in[7:4] == HLT_OPCODE) begin
          r_halted <= 1'b1;
        end
      end
      if (w_accept_load && out_en) begin
        r_conflict <= 1'b1;
      end
    end
  end

  assign opcode   = r_ir[7:4];
  assign operand  = r_ir[3:0];
  assign bus_out  = {4'b0000, r_ir[3:0]};
  // Never drive the bus while loading from it.
  assign bus_oe   = out_en & r_valid & ~load;
  assign valid    = r_valid;
  assign illegal  = r_valid & ~op_is_legal(LEGAL_MASK, r_ir[7:4]);
  assign halted   = r_halted;
  assign conflict = r_conflict;
  assign retired  = r_retired;

endmodule : instruction_register

`default_nettype wire
